// File: rtl/skid_reg32.sv
// skid_reg32: two-entry skid register for a 32-bit valid/ready stream.
//
// Handshake: a word moves across an interface on a rising edge when both
// valid and ready are high on that interface. in_ready is a function of
// registered state only, so no combinational path runs from out_ready or
// in_valid to in_ready. out_valid/data_out likewise come from registers.
//
// Storage is a main entry (always the oldest word, drives data_out) and a
// skid entry that catches the one word accepted while downstream stalls.
// The occupancy state doubles as the count output and serves as the
// observable FSM state.
module skid_reg32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] data_in,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] data_out,
    input  logic        out_ready,
    input  logic        flush,
    output logic [1:0]  count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] main_q;
    logic [31:0] skid_q;

    logic in_fire;
    logic out_fire;

    // Outputs decode directly from registered state.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign data_out  = main_q;
    assign count     = state_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Occupancy FSM and data entries; flush overrides every other event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            main_q  <= 32'h0;
            skid_q  <= 32'h0;
        end else if (flush) begin
            state_q <= EMPTY;
            main_q  <= 32'h0;
            skid_q  <= 32'h0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_q <= ONE;
                        main_q  <= data_in;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= data_in;
                    end else if (in_fire) begin
                        // Downstream stalled: park the new word behind main.
                        state_q <= FULL;
                        skid_q  <= data_in;
                    end else if (out_fire) begin
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a drain can happen.
                    if (out_fire) begin
                        state_q <= ONE;
                        main_q  <= skid_q;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_skid_reg32.sv
// Testbench for skid_reg32: directed vectors, scoreboard queue of expected
// words, monitor on the falling edge comparing outputs against a small
// occupancy model.
module tb_skid_reg32;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] data_in;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] data_out;
  logic        out_ready;
  logic        flush;
  logic [1:0]  count;

  logic [31:0] exp_q[$];
  int          m_cnt;
  bit          m_zero;
  int          n_total;
  int          n_bad;

  skid_reg32 dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .data_out  (data_out),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- comparison helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after the rising edge and hold for a full cycle.
  task automatic step(input logic v, input logic [31:0] d, input logic ordy, input logic fl);
    in_valid  = v;
    data_in   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b0, 32'hDEAD_BEEF, ordy, 1'b0);
  endtask

  // ---------------- scoreboard / monitor ----------------
  // On each falling edge: compare outputs with the model, then advance the
  // model by what the coming rising edge will do with the current inputs.
  always @(negedge clk) begin
    bit in_f;
    bit out_f;
    if (!reset) begin
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_data_out", data_out, 32'h0);
      chk("rst_count", {30'b0, count}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      exp_q.delete();
      m_cnt  = 0;
      m_zero = 1'b1;
    end else begin
      chk("count", {30'b0, count}, m_cnt);
      chk("in_ready", {31'b0, in_ready}, {31'b0, (m_cnt != 2)});
      chk("out_valid", {31'b0, out_valid}, {31'b0, (m_cnt != 0)});
      if (m_cnt != 0 && exp_q.size() != 0) chk("data_out", data_out, exp_q[0]);
      else if (m_zero) chk("data_out_zero", data_out, 32'h0);
      in_f  = in_valid && (m_cnt != 2);
      out_f = out_ready && (m_cnt != 0);
      if (flush) begin
        exp_q.delete();
        m_cnt  = 0;
        m_zero = 1'b1;
      end else begin
        if (out_f) void'(exp_q.pop_front());
        if (in_f) begin
          exp_q.push_back(data_in);
          m_zero = 1'b0;
        end
        m_cnt = m_cnt + int'(in_f) - int'(out_f);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_total   = 0;
    n_bad     = 0;
    m_cnt     = 0;
    m_zero    = 1'b1;
    reset     = 1'b0;
    in_valid  = 1'b0;
    data_in   = 32'h0;
    out_ready = 1'b0;
    flush     = 1'b0;

    // Reset held with random inputs.
    for (int i = 0; i < 5; i++)
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    reset = 1'b1;
    idle(2, 1'b1);

    // Streaming with out_ready held high.
    step(1'b1, 32'h1, 1'b1, 1'b0);
    step(1'b1, 32'h2, 1'b1, 1'b0);
    step(1'b1, 32'h3, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Backpressure: A, B fill; C refused; drain.
    step(1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0);
    step(1'b1, 32'hC, 1'b0, 1'b0);
    step(1'b1, 32'hC, 1'b0, 1'b0);
    chk("bp_count", {30'b0, count}, 32'd2);
    chk("bp_data", data_out, 32'hA);
    idle(3, 1'b1);
    chk("bp_drained", {30'b0, count}, 32'd0);

    // Simultaneous push and pop while holding one word.
    step(1'b1, 32'h5, 1'b0, 1'b0);
    step(1'b1, 32'h6, 1'b1, 1'b0);
    chk("sim_count", {30'b0, count}, 32'd1);
    chk("sim_data", data_out, 32'h6);
    idle(2, 1'b1);

    // Flush in FULL with coincident push and pop.
    step(1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0);
    step(1'b1, 32'hC, 1'b1, 1'b1);
    chk("flush_count", {30'b0, count}, 32'd0);
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_data", data_out, 32'h0);
    idle(3, 1'b1);

    // Asynchronous reset between edges while FULL.
    step(1'b1, 32'h11, 1'b0, 1'b0);
    step(1'b1, 32'h22, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_count", {30'b0, count}, 32'd0);
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_data", data_out, 32'h0);
    chk("arst_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(1, 1'b1);

    // Recovery after reset, sustained stream.
    step(1'b1, 32'h7, 1'b1, 1'b0);
    step(1'b1, 32'h8, 1'b1, 1'b0);
    idle(3, 1'b1);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/skid_reg32.md
SKID_REG32 -- requirements
Module: skid_reg32

Interface
REQ-001 The block SHALL have ports: clk  input  1  single clock, all state updates on rising edge.
REQ-002 The block SHALL have ports: reset  input  1  asynchronous, active-low; 0 forces reset state immediately, independent of clk.
REQ-003 The block SHALL have ports: in_valid  input  1  upstream word available on data_in.
REQ-004 The block SHALL have ports: data_in  input  32  upstream word.
REQ-005 The block SHALL have ports: in_ready  output  1  block accepts a word this cycle.
REQ-006 The block SHALL have ports: out_valid  output  1  data_out holds a valid word.
REQ-007 The block SHALL have ports: data_out  output  32  oldest held word.
REQ-008 The block SHALL have ports: out_ready  input  1  downstream consumes data_out this cycle.
REQ-009 The block SHALL have ports: flush  input  1  synchronous discard of all held words.
REQ-010 The block SHALL have ports: count  output  2  words held (0..2).

Function
REQ-011 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready; both SHALL be evaluated on the same rising edge.
REQ-012 Storage SHALL be two 32-bit entries: main (drives data_out) and skid; a 3-state FSM SHALL track occupancy: EMPTY(0), ONE(1), FULL(2).
REQ-013 in_ready SHALL equal (state != FULL) and SHALL depend only on registered state, with no combinational path from out_ready or in_valid.
REQ-014 out_valid SHALL equal (state != EMPTY); data_out SHALL equal main; count SHALL equal the state encoding.
REQ-015 EMPTY: in_fire -> ONE with main <= data_in; otherwise stay EMPTY.
REQ-016 ONE: in_fire & out_fire -> ONE with main <= data_in.
REQ-017 ONE: in_fire & !out_fire -> FULL with skid <= data_in and main unchanged.
REQ-018 ONE: !in_fire & out_fire -> EMPTY.
REQ-019 ONE: neither in_fire nor out_fire -> hold.
REQ-020 FULL: out_fire -> ONE with main <= skid; otherwise hold; in_fire cannot occur in FULL.
REQ-021 Latency SHALL be 1 cycle: a word accepted at edge N SHALL appear on data_out with out_valid=1 after edge N.
REQ-022 Ordering SHALL be strict FIFO; no word SHALL be dropped or duplicated absent flush/reset.
REQ-023 While out_valid=1 and out_ready=0, data_out SHALL remain stable.
REQ-024 Entries not being loaded SHALL hold their value; data_in SHALL be ignored when in_fire=0.
REQ-025 flush=1 at an edge SHALL take priority over all other events: state -> EMPTY, main and skid -> 0, and any coincident in_fire or out_fire word is discarded.
REQ-026 Throughput SHALL be one word per cycle sustained when out_ready is held 1.

Reset
REQ-027 reset=0 SHALL asynchronously set state=EMPTY, main=0, and skid=0, giving out_valid=0, data_out=32'h0, count=0, and in_ready=1.
REQ-028 In-flight words SHALL be lost when reset asserts mid-operation.
REQ-029 After reset deasserts, the first rising edge SHALL behave as in EMPTY.
REQ-030 No input SHALL be sampled while reset=0.

Verification
REQ-031 Reset: hold reset=0 with random inputs/clk -> out_valid=0, data_out=0, count=0, in_ready=1 throughout; release -> same values until the first in_fire.
REQ-032 Streaming: out_ready=1, push 32'h1, 32'h2, 32'h3 on consecutive edges -> data_out shows 1, 2, 3 one cycle after each push, count=1, in_ready stays 1.
REQ-033 Backpressure: out_ready=0, push 32'hA then 32'hB -> count=2, in_ready=0, data_out=A stable; further in_valid=1 with 32'hC is not accepted; raise out_ready -> A, then B, then count=0.
REQ-034 Simultaneous: in ONE holding 32'h5, in_fire 32'h6 with out_fire -> count=1, data_out=6 next cycle.
REQ-035 Flush: in FULL (A, B), assert flush with in_valid=1, data_in=32'hC and out_ready=1 -> next cycle count=0, out_valid=0, data_out=0, and C is never output.
REQ-036 Async reset mid-stream: assert reset=0 between clock edges in FULL -> outputs go to reset values before the next edge.
